// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes, FSM states,
// byte-lane masks and load-data extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    function automatic logic [2:0] size_bytes(input mem_size_t size);
        logic [2:0] n;
        case (size)
            MEM_B:   n = 3'd1;
            MEM_H:   n = 3'd2;
            MEM_W:   n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Byte enables across {high word, low word}; bits 7:4 belong to the next word.
    function automatic logic [7:0] lane_mask(input logic [1:0] offset, input mem_size_t size);
        logic [7:0] base;
        case (size)
            MEM_B:   base = 8'h01;
            MEM_H:   base = 8'h03;
            MEM_W:   base = 8'h0F;
            default: base = 8'h0F;
        endcase
        return base << offset;
    endfunction

    function automatic logic crosses(input logic [1:0] offset, input mem_size_t size);
        return (({1'b0, offset} + size_bytes(size)) > 3'd4);
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input mem_size_t size,
                                                input logic sgn);
        logic [31:0] r;
        case (size)
            MEM_B:   r = {{24{sgn & raw[7]}}, raw[7:0]};
            MEM_H:   r = {{16{sgn & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the M stage (master) and the data-memory responder (slave).
interface dmem_if #(
    parameter int ADDR_W = 13
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dmem_bank.sv
// Single-port synchronous 32-bit RAM with four byte-lane write enables.
// Read data updates only on enabled cycles with no lane written.
module dmem_bank #(
    parameter int DEPTH_W = 11
) (
    input  logic               clk,
    input  logic               en,
    input  logic [3:0]         we,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);
    logic [31:0] mem_r [2**DEPTH_W];
    logic [31:0] rdata_r;

    // Byte-lane writes or a registered word read
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == 4'h0) begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts load/store requests, splits word-crossing accesses into
// two bank cycles and returns extended load data (or a store ack) one pulse per request.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int IDX_W = ADDR_W - 2;

    state_t            state_r, nextState_s;
    logic [ADDR_W-1:0] capAddr_r;
    mem_size_t         capSize_r;
    logic              capSigned_r, capWrite_r, capSplit_r, rspValid_r;
    logic [31:0]       capWdata_r, lowWord_r, heldRdata_r;

    mem_size_t         reqSize_s, selSize_s;
    logic              reqCross_s, ready_s, bankEn_s;
    logic [1:0]        selOff_s;
    logic [31:0]       selWdata_s, bankWdata_s, bankRdata_s, loadShift_s, rdataAsm_s;
    logic [7:0]        laneMask_s;
    logic [63:0]       laneData_s, loadCat_s;
    logic [3:0]        bankWe_s;
    logic [IDX_W-1:0]  bankIdx_s;

    assign reqSize_s  = mem_size_t'(bus.req_size);
    assign reqCross_s = crosses(bus.req_addr[1:0], reqSize_s);

    // Lane steering source: live request in IDLE, captured request during SPLIT
    always_comb begin
        selOff_s   = bus.req_addr[1:0];
        selSize_s  = reqSize_s;
        selWdata_s = bus.req_wdata;
        if (state_r == SPLIT) begin
            selOff_s   = capAddr_r[1:0];
            selSize_s  = capSize_r;
            selWdata_s = capWdata_r;
        end else begin
            selOff_s   = bus.req_addr[1:0];
        end
        laneMask_s = lane_mask(selOff_s, selSize_s);
        laneData_s = {32'h0000_0000, selWdata_s} << {selOff_s, 3'b000};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic: a crossing request costs exactly one extra cycle
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE:    nextState_s = (bus.req_valid && reqCross_s) ? SPLIT : IDLE;
            SPLIT:   nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Output logic: handshake and bank controls for the low or high word part
    always_comb begin
        ready_s     = 1'b1;
        bankEn_s    = 1'b0;
        bankWe_s    = 4'h0;
        bankIdx_s   = bus.req_addr[ADDR_W-1:2];
        bankWdata_s = laneData_s[31:0];
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    bankEn_s = 1'b1;
                    bankWe_s = bus.req_write ? laneMask_s[3:0] : 4'h0;
                end else begin
                    bankEn_s = 1'b0;
                end
            end
            SPLIT: begin
                ready_s     = 1'b0;
                bankEn_s    = 1'b1;
                bankIdx_s   = capAddr_r[ADDR_W-1:2] + {{(IDX_W-1){1'b0}}, 1'b1};
                bankWdata_s = laneData_s[63:32];
                bankWe_s    = capWrite_r ? laneMask_s[7:4] : 4'h0;
            end
            default: ready_s = 1'b1;
        endcase
    end

    dmem_bank #(.DEPTH_W(IDX_W)) u_bank (
        .clk   (clk),
        .en    (bankEn_s),
        .we    (bankWe_s),
        .addr  (bankIdx_s),
        .wdata (bankWdata_s),
        .rdata (bankRdata_s)
    );

    // Request capture, split low-word holding and response bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            capAddr_r   <= '0;
            capSize_r   <= MEM_W;
            capSigned_r <= 1'b0;
            capWrite_r  <= 1'b0;
            capSplit_r  <= 1'b0;
            capWdata_r  <= 32'h0000_0000;
            lowWord_r   <= 32'h0000_0000;
            heldRdata_r <= 32'h0000_0000;
            rspValid_r  <= 1'b0;
        end else begin
            rspValid_r <= 1'b0;
            if (state_r == SPLIT) begin
                rspValid_r <= 1'b1;
                lowWord_r  <= bankRdata_s;
            end else if (bus.req_valid) begin
                capAddr_r   <= bus.req_addr;
                capSize_r   <= reqSize_s;
                capSigned_r <= bus.req_signed;
                capWrite_r  <= bus.req_write;
                capWdata_r  <= bus.req_wdata;
                capSplit_r  <= reqCross_s;
                rspValid_r  <= !reqCross_s;
            end
            if (rspValid_r) begin
                heldRdata_r <= rdataAsm_s;
            end
        end
    end

    // Load data assembly: join words, align to byte 0, then size-extend
    always_comb begin
        loadCat_s   = capSplit_r ? {bankRdata_s, lowWord_r} : {32'h0000_0000, bankRdata_s};
        loadShift_s = 32'(loadCat_s >> {capAddr_r[1:0], 3'b000});
        if (capWrite_r) begin
            rdataAsm_s = 32'h0000_0000;
        end else begin
            rdataAsm_s = extend_load(loadShift_s, capSize_r, capSigned_r);
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rspValid_r;
    assign bus.rsp_rdata = rspValid_r ? rdataAsm_s : heldRdata_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: byte-array reference model with a per-cycle compare process,
// directed literal checks and randomized load/store traffic.
module tb_dmem_responder;
    localparam int AW     = 13;
    localparam int NBYTES = 8192;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(AW)) ifc ();

    dmem_responder #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    logic [7:0]  mdl [NBYTES];
    int          cyc = 0;
    bit          expV [int];
    logic [31:0] expD [int];
    bit          busy [int];
    logic [31:0] lastRsp = 32'h0;
    bit          chkEn = 1'b0;
    int          nCmp = 0;
    int          nBad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        nCmp++;
        if (got !== want) begin
            nBad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic check1(input string nm, input logic got, input logic want);
        check(nm, {31'h0, got}, {31'h0, want});
    endtask

    // Reference: memory is a flat byte array, accesses wrap modulo its size.
    function automatic logic [31:0] modelAccess(input bit w, input logic [1:0] sz, input bit sg,
                                                input logic [12:0] a, input logic [31:0] wd,
                                                input bit partial);
        int nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        int off = int'(a[1:0]);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nb; i++) begin
            int ba = (int'(a) + i) % NBYTES;
            if (w) begin
                if (!partial || (off + i) < 4) mdl[ba] = wd[8*i +: 8];
            end else begin
                v[8*i +: 8] = mdl[ba];
            end
        end
        if (w) return 32'h0;
        if (nb == 1) v = {{24{sg & v[7]}}, v[7:0]};
        if (nb == 2) v = {{16{sg & v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic doReq(input bit w, input logic [1:0] sz, input bit sg, input logic [12:0] a,
                         input logic [31:0] wd, input bit partial, output int rc);
        bit got = 1'b0;
        int k, nb;
        logic [31:0] d;
        ifc.req_valid  = 1'b1;
        ifc.req_write  = w;
        ifc.req_size   = sz;
        ifc.req_signed = sg;
        ifc.req_addr   = a;
        ifc.req_wdata  = wd;
        rc = -1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (ifc.req_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            nCmp++;
            nBad++;
            $display("FAIL accept_timeout: req_ready stayed %b at addr %h", ifc.req_ready, a);
            ifc.req_valid = 1'b0;
            return;
        end
        k  = cyc;
        d  = modelAccess(w, sz, sg, a, wd, partial);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (!partial) begin
            if (int'(a[1:0]) + nb > 4) begin
                busy[k+1] = 1'b1;
                expV[k+2] = 1'b1;
                expD[k+2] = d;
                rc = k + 2;
            end else begin
                expV[k+1] = 1'b1;
                expD[k+1] = d;
                rc = k + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit w, input logic [1:0] sz, input bit sg, input logic [12:0] a,
                       input logic [31:0] wd);
        int rc;
        doReq(w, sz, sg, a, wd, 1'b0, rc);
        ifc.req_valid = 1'b0;
    endtask

    task automatic reqLit(input bit w, input logic [1:0] sz, input bit sg, input logic [12:0] a,
                          input logic [31:0] wd, input string nm, input logic [31:0] lit);
        int rc;
        doReq(w, sz, sg, a, wd, 1'b0, rc);
        ifc.req_valid = 1'b0;
        for (int t = 0; t < 4 && cyc < rc; t++) begin
            @(posedge clk);
            #1;
        end
        #2;
        check1({nm, "_valid"}, ifc.rsp_valid, 1'b1);
        check(nm, ifc.rsp_rdata, lit);
    endtask

    // Every cycle: handshake, pulse and data (or held data) against the model
    initial begin
        forever begin
            bit ev;
            @(negedge clk);
            if (chkEn) begin
                ev = expV.exists(cyc);
                check1("req_ready", ifc.req_ready, !busy.exists(cyc));
                check1("rsp_valid", ifc.rsp_valid, ev);
                if (ev) begin
                    check("rsp_rdata", ifc.rsp_rdata, expD[cyc]);
                    lastRsp = expD[cyc];
                    expV.delete(cyc);
                    expD.delete(cyc);
                end else begin
                    check("rsp_hold", ifc.rsp_rdata, lastRsp);
                end
                if (busy.exists(cyc)) busy.delete(cyc);
            end
        end
    end

    initial begin
        int rc;
        ifc.req_valid  = 1'b0;
        ifc.req_write  = 1'b0;
        ifc.req_size   = 2'b00;
        ifc.req_signed = 1'b0;
        ifc.req_addr   = '0;
        ifc.req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_ready", ifc.req_ready, 1'b1);
        check1("rst_valid", ifc.rsp_valid, 1'b0);
        check("rst_rdata", ifc.rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chkEn = 1'b1;

        reqLit(1'b1, 2'b10, 1'b0, 13'h010, 32'hDEADBEEF, "store_ack", 32'h0);
        reqLit(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, "lw_010", 32'hDEADBEEF);
        reqLit(1'b0, 2'b00, 1'b1, 13'h013, 32'h0, "lb_013", 32'hFFFFFFDE);
        reqLit(1'b0, 2'b00, 1'b0, 13'h013, 32'h0, "lbu_013", 32'h000000DE);
        reqLit(1'b0, 2'b01, 1'b1, 13'h012, 32'h0, "lh_012", 32'hFFFFDEAD);
        req(1'b1, 2'b00, 1'b0, 13'h011, 32'h00000055);
        reqLit(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, "lw_after_sb", 32'hDEAD55EF);
        req(1'b1, 2'b10, 1'b0, 13'h00C, 32'h44332211);
        req(1'b1, 2'b10, 1'b0, 13'h010, 32'h88776655);
        reqLit(1'b0, 2'b10, 1'b0, 13'h00E, 32'h0, "lw_split_00E", 32'h66554433);
        req(1'b1, 2'b01, 1'b0, 13'h00F, 32'h0000ABCD);
        reqLit(1'b0, 2'b00, 1'b0, 13'h00F, 32'h0, "byte_00F", 32'h000000CD);
        reqLit(1'b0, 2'b00, 1'b0, 13'h010, 32'h0, "byte_010", 32'h000000AB);
        reqLit(1'b0, 2'b00, 1'b0, 13'h00E, 32'h0, "byte_00E", 32'h00000033);
        reqLit(1'b0, 2'b00, 1'b0, 13'h011, 32'h0, "byte_011", 32'h00000066);
        req(1'b1, 2'b10, 1'b0, 13'h1FFC, 32'hA1B2C3D4);
        req(1'b1, 2'b10, 1'b0, 13'h000, 32'h0A0B0C0D);
        reqLit(1'b0, 2'b10, 1'b0, 13'h1FFE, 32'h0, "lw_wrap", 32'h0C0DA1B2);

        // Four aligned loads on consecutive cycles
        doReq(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 1'b0, rc);
        doReq(1'b0, 2'b10, 1'b0, 13'h00C, 32'h0, 1'b0, rc);
        doReq(1'b0, 2'b10, 1'b0, 13'h000, 32'h0, 1'b0, rc);
        doReq(1'b0, 2'b10, 1'b0, 13'h1FFC, 32'h0, 1'b0, rc);
        ifc.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a split store
        req(1'b1, 2'b10, 1'b0, 13'h020, 32'h00000000);
        req(1'b1, 2'b10, 1'b0, 13'h024, 32'hFFFFFFFF);
        doReq(1'b1, 2'b10, 1'b0, 13'h021, 32'h11223344, 1'b1, rc);
        chkEn = 1'b0;
        ifc.req_valid = 1'b0;
        check1("split_ready_low", ifc.req_ready, 1'b0);
        rst = 1'b0;
        #1;
        check1("midrst_ready", ifc.req_ready, 1'b1);
        check1("midrst_valid", ifc.rsp_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        lastRsp = 32'h0;
        expV.delete();
        expD.delete();
        busy.delete();
        chkEn = 1'b1;
        reqLit(1'b0, 2'b10, 1'b0, 13'h020, 32'h0, "partial_low", 32'h22334400);
        reqLit(1'b0, 2'b10, 1'b0, 13'h024, 32'h0, "partial_high", 32'hFFFFFFFF);

        // Randomized traffic over an initialised low region and the top words
        for (int i = 0; i <= 16; i++) req(1'b1, 2'b10, 1'b0, 13'(4 * i), $urandom);
        for (int i = 2044; i < 2048; i++) req(1'b1, 2'b10, 1'b0, 13'(4 * i), $urandom);
        for (int n = 0; n < 300; n++) begin
            logic [12:0] a;
            if ($urandom_range(0, 9) < 8) a = 13'($urandom_range(0, 63));
            else                          a = 13'h1FF0 + 13'($urandom_range(0, 15));
            doReq(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom, 1'b0, rc);
            if ($urandom_range(0, 3) == 0) begin
                ifc.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        ifc.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the data-memory interface driven by the M stage.
- Accepts load/store requests through a valid/ready handshake and returns read data, or a store acknowledge, on a registered response port.
- Handles byte, halfword and word sizes with sign or zero extension, and stores through byte-lane writes.
- Splits accesses that cross a word boundary into two word accesses, holding off new requests until the split finishes.

Parameters:
- ADDR_W, 13, byte-address width; storage is 2**(ADDR_W-2) 32-bit words, little-endian.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_signed  in  1  sign-extend load data (ignored for word)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  32  extended load data; 0 for stores

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0.
  - Memory contents are not cleared.
- Handshake:
  - A request is accepted on a rising edge where req_valid and req_ready are both 1.
  - The requester holds all request fields stable while req_ready=0.
- Misalignment:
  - Span = req_addr[1:0] + size_bytes - 1.
  - Span > 3 means the access crosses a word boundary.
  - Word index = req_addr[ADDR_W-1:2]. The second word is index+1, wrapping modulo depth, so the top word wraps to word 0.
- State IDLE, aligned request accepted at edge 0:
  - Loads: word read synchronously at edge 0.
  - Stores: write with byte enables derived from offset and size at edge 0.
  - rsp_valid=1 during cycle 1.
  - req_ready stays 1, so back-to-back aligned requests sustain one per cycle.
- State IDLE, crossing request accepted at edge 0:
  - Captures addr, size, signed and wdata.
  - Edge 0 performs the low-word part: read word index, or write its upper lanes.
  - Moves to SPLIT.
- State SPLIT (exactly one cycle):
  - req_ready=0.
  - Edge 1 performs the high-word part: read word index+1, or write its lower lanes.
  - Returns to IDLE.
  - rsp_valid=1 during cycle 2; req_ready=1 again in cycle 2.
- Load data assembly:
  - Concatenate {high word, low word} when split.
  - Shift right by 8*offset.
  - Mask to the access size.
  - Sign-extend from bit 7 or 15 if req_signed, otherwise zero-extend.
- Store data placement:
  - req_wdata[8*size_bytes-1:0] is shifted left by 8*offset across the two words.
  - Only the addressed bytes are written; all other bytes are untouched.
- Read-after-write:
  - A load accepted the cycle after a store to the same word returns the new data.
  - The RAM is write-first across edges with no bypass needed, because each access completes at its own edge.
- Reset mid-split: the second half is abandoned and no rsp_valid is issued. A partial store leaves the low word written and the high word unchanged.
- rsp_rdata holds its last value while rsp_valid=0.

Decomposition:
- Package dmem_pkg:
  - mem_size_t enum: MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10.
  - Function size_bytes(mem_size_t).
  - Function lane_mask(offset, size) returning an 8-bit two-word byte-enable vector.
  - State enum {IDLE, SPLIT}.
- Sub-module dmem_bank: single-port synchronous RAM, 4 byte lanes with per-lane write enables, parameterised depth.
- The top level holds the FSM, capture registers, lane steering and extension logic.

Test Plan:
- Reset then word store of 0xDEADBEEF to addr 0x010 -> rsp_valid at cycle 1, rsp_rdata=0. Word load from 0x010 -> rsp_rdata=0xDEADBEEF at cycle 1 after accept.
- Signed byte load at 0x013 (byte 0xDE) -> 0xFFFFFFDE. Unsigned -> 0x000000DE. Signed halfword at 0x012 -> 0xFFFFDEAD.
- Byte store 0x55 to 0x011 -> word at 0x010 reads 0xDEAD55EF; other bytes are unchanged.
- Misaligned word load at 0x00E, with word 0x00C=0x44332211 and word 0x010=0x88776655 -> req_ready=0 in cycle 1, rsp_valid in cycle 2, rsp_rdata=0x66554433.
- Misaligned halfword store 0xABCD at 0x00F -> byte 0x00F=0xCD, byte 0x010=0xAB, neighbours unchanged. Top-word wrap: word load at 0x1FFE (ADDR_W=13) reads the high bytes from word 0.
- Back-to-back aligned loads on 4 consecutive cycles -> 4 consecutive rsp_valid pulses with correct data. rst asserted during SPLIT of a misaligned store -> no rsp_valid, req_ready=1 after reset release, low word modified and high word intact.
